parking_occupancy_counter: RTL and testbench
============================================

# parking_occupancy_counter

Parametrised car-park occupancy counter. Two photo-barrier inputs are synchronised and debounced, then decoded by a direction state machine into entry/exit events. The events drive a saturating multi-digit BCD up/down counter with full/empty status. It sits between the barrier sensor pins and the seven-segment display controller, which consumes `count_bcd` directly.

## Interface
- `DIGITS`, 4: number of BCD digits in `count_bcd`.
- `CAPACITY`, 50: maximum occupancy. Must satisfy 1 ≤ CAPACITY ≤ 10^DIGITS − 1.
- `DEBOUNCE`, 4: consecutive stable cycles (≥1) required before a filtered sensor changes.
- `clk`  in  1  single system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `a`  in  1  outer barrier, 1 = beam blocked; asynchronous to `clk`.
- `b`  in  1  inner barrier, 1 = beam blocked; asynchronous to `clk`.
- `clear`  in  1  synchronous count clear, level.
- `entra`  out  1  one-cycle pulse per completed entry.
- `sale`  out  1  one-cycle pulse per completed exit.
- `error`  out  1  one-cycle pulse on an illegal sensor transition.
- `reject`  out  1  one-cycle pulse when an event cannot change the count (entry at full, exit at empty).
- `full`  out  1  count == CAPACITY.
- `empty`  out  1  count == 0.
- `count_bcd`  out  4*DIGITS  occupancy, one BCD digit per nibble; digit 0 in [3:0].

## Operation
- **Input path:** per sensor, 2-flop synchroniser, then debounce counter.
  - The counter increments while synced ≠ filtered and resets to 0 when they are equal.
  - On reaching DEBOUNCE, filtered takes the synced value and the counter resets.
- **Direction FSM** on filtered (a,b). States: IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_AB, OUT_A, ERR.
  - IDLE: 10→IN_A; 01→OUT_B; 11→ERR; 00 stays.
  - IN_A: 11→IN_AB; 00→IDLE (abandoned, no event); 01→ERR.
  - IN_AB: 01→IN_B; 10→IN_A (backing out); 00→ERR.
  - IN_B: 00→IDLE with `entra`; 11→IN_AB; 10→ERR.
  - OUT_B / OUT_AB / OUT_A mirror the entry states with a and b swapped. OUT_A 00→IDLE with `sale`.
  - ERR: stays until filtered == 00, then →IDLE. No events are generated while in ERR.
  - `error` pulses only on the transition into ERR.
- **Counter:** DIGITS-digit BCD, decimal carry/borrow rippled across digits within one cycle.
  - Priority: `clear` > entry/exit.
  - `entra` with count < CAPACITY: +1.
  - `entra` with count == CAPACITY: count held, `reject` pulses.
  - `sale` with count > 0: −1.
  - `sale` with count == 0: count held, `reject` pulses.
  - `entra` and `sale` are mutually exclusive by construction.
  - `clear` in the same cycle as an event: count → 0, `reject` low; the `entra`/`sale` pulse is still emitted.
- `full` and `empty` are combinational decodes of the count register.
- **Reset values:** `entra`=`sale`=`error`=`reject`=0, `count_bcd`=0, `empty`=1, `full`=0. FSM in IDLE; synchronisers, filtered values and debounce counters all 0.
- Reset asserted mid-sequence abandons the sequence: no event is emitted and the count returns to 0.

## Timing
- Raw pin change stable from edge k: synced value visible at k+2, filtered updates at k+2+DEBOUNCE.
- `entra`, `sale`, `error`: registered, asserted exactly one cycle, at k+3+DEBOUNCE relative to the final sensor change.
- `count_bcd`, `full`, `empty`, `reject`: updated on the edge after the event pulse, at k+4+DEBOUNCE.
- `clear`: count is 0 on the edge after `clear` is sampled high.
- Glitches shorter than DEBOUNCE cycles (post-synchroniser) produce no filtered change and no output activity.
- Back-to-back vehicles are supported: a new sequence may start in the cycle after the FSM returns to IDLE.

## Test plan
- **Entry:** defaults; from reset, apply a,b = 10, 11, 01, 00, each held 10 cycles. Expect one `entra` pulse, `count_bcd`=0x0001, `empty` 1→0. Check pulse-to-count latency is exactly 1 cycle.
- **Exit at zero and after entries:**
  - Exit sequence 01, 11, 10, 00 at count 0: `sale` and `reject` pulse, count stays 0.
  - After three entries then one exit: count 0x0002.
- **Saturation and carry:** CAPACITY=12, DIGITS=2; 13 entries. Expect count 0x09→0x10 on the 10th entry, `full`=1 at 0x12, and a `reject` pulse on the 13th with count held at 0x12. Then one exit: 0x11, `full`=0.
- **Illegal, bounce and abandon:**
  - From IDLE apply 11: one `error` pulse; FSM waits for 00; count unchanged.
  - A 2-cycle pulse on `a` with DEBOUNCE=4: no output activity.
  - Sequence 10, 00 (abandoned entry): no event.
- **Clear and reset:**
  - `clear` in the same cycle as an `entra` pulse at count 5: count 0, no `reject`.
  - Async `reset` mid-entry while in IN_AB: outputs immediately return to reset values, and a subsequent full entry counts to 1.

Source files
------------

// File: rtl/parking_occupancy_counter.sv
// rtl/parking_occupancy_counter.sv - barrier sensors to debounced direction events and saturating BCD occupancy count
module parking_occupancy_counter #(
  parameter int DIGITS   = 4,
  parameter int CAPACITY = 50,
  parameter int DEBOUNCE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a,
  input  logic                  b,
  input  logic                  clear,
  output logic                  entra,
  output logic                  sale,
  output logic                  error,
  output logic                  reject,
  output logic                  full,
  output logic                  empty,
  output logic [4*DIGITS-1:0]   count_bcd
);

  localparam int NW = 4 * DIGITS;
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE);

  function automatic logic [NW-1:0] to_bcd(input int value);
    logic [NW-1:0] r;
    int            v;
    r = '0;
    v = value;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  localparam logic [NW-1:0] CAP_BCD = to_bcd(CAPACITY);

  typedef enum logic [2:0] {
    IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_AB, OUT_A, ERR
  } state_t;

  // Index 0 carries sensor a, index 1 carries sensor b.
  logic [1:0]    raw;
  logic [1:0]    sync1_q, sync2_q, filt_q;
  logic [CW-1:0] dcnt_q [2];
  logic [1:0]    ab;

  state_t        state_q;
  logic          entra_q, sale_q, error_q, reject_q, reject_d;
  logic [NW-1:0] count_q, count_d, count_inc, count_dec;
  logic          carry, borrow;

  assign raw = {b, a};
  assign ab  = {filt_q[0], filt_q[1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      filt_q    <= '0;
      dcnt_q[0] <= '0;
      dcnt_q[1] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          dcnt_q[i] <= '0;
        end else if (dcnt_q[i] + CW'(1) == DB_MAX) begin
          filt_q[i] <= sync2_q[i];
          dcnt_q[i] <= '0;
        end else begin
          dcnt_q[i] <= dcnt_q[i] + CW'(1);
        end
      end
    end
  end

  // ab is {a,b}: the entry path walks 10,11,01,00 and the exit path 01,11,10,00.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      entra_q <= 1'b0;
      sale_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      entra_q <= 1'b0;
      sale_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          case (ab)
            2'b10:   state_q <= IN_A;
            2'b01:   state_q <= OUT_B;
            2'b11:   begin state_q <= ERR; error_q <= 1'b1; end
            default: ;
          endcase
        end
        IN_A: begin
          case (ab)
            2'b11:   state_q <= IN_AB;
            2'b00:   state_q <= IDLE;
            2'b01:   begin state_q <= ERR; error_q <= 1'b1; end
            default: ;
          endcase
        end
        IN_AB: begin
          case (ab)
            2'b01:   state_q <= IN_B;
            2'b10:   state_q <= IN_A;
            2'b00:   begin state_q <= ERR; error_q <= 1'b1; end
            default: ;
          endcase
        end
        IN_B: begin
          case (ab)
            2'b00:   begin state_q <= IDLE; entra_q <= 1'b1; end
            2'b11:   state_q <= IN_AB;
            2'b10:   begin state_q <= ERR; error_q <= 1'b1; end
            default: ;
          endcase
        end
        OUT_B: begin
          case (ab)
            2'b11:   state_q <= OUT_AB;
            2'b00:   state_q <= IDLE;
            2'b10:   begin state_q <= ERR; error_q <= 1'b1; end
            default: ;
          endcase
        end
        OUT_AB: begin
          case (ab)
            2'b10:   state_q <= OUT_A;
            2'b01:   state_q <= OUT_B;
            2'b00:   begin state_q <= ERR; error_q <= 1'b1; end
            default: ;
          endcase
        end
        OUT_A: begin
          case (ab)
            2'b00:   begin state_q <= IDLE; sale_q <= 1'b1; end
            2'b11:   state_q <= OUT_AB;
            2'b01:   begin state_q <= ERR; error_q <= 1'b1; end
            default: ;
          endcase
        end
        ERR: begin
          if (ab == 2'b00) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    count_inc = count_q;
    count_dec = count_q;
    carry     = 1'b1;
    borrow    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          count_dec[4*i +: 4] = 4'd9;
        end else begin
          count_dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  // Count never exceeds CAPACITY, so "below capacity" is simply "not full".
  always_comb begin
    count_d  = count_q;
    reject_d = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (entra_q) begin
      if (full) reject_d = 1'b1;
      else      count_d  = count_inc;
    end else if (sale_q) begin
      if (empty) reject_d = 1'b1;
      else       count_d  = count_dec;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      reject_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      reject_q <= reject_d;
    end
  end

  assign full      = (count_q == CAP_BCD);
  assign empty     = (count_q == '0);
  assign count_bcd = count_q;
  assign entra     = entra_q;
  assign sale      = sale_q;
  assign error     = error_q;
  assign reject    = reject_q;

endmodule

// File: tb/tb_parking_occupancy_counter.sv
// tb/tb_parking_occupancy_counter.sv - directed bench for the default build and a 2-digit capacity-12 build
module tb_parking_occupancy_counter;

  logic clk = 1'b0;
  logic reset, a, b, clear;

  logic        e0, s0, er0, rj0, f0, em0;
  logic [15:0] c0;
  logic        e1, s1, er1, rj1, f1, em1;
  logic [7:0]  c1;

  int total = 0;
  int bad   = 0;
  int ne0 = 0, ns0 = 0, nerr0 = 0, nrj0 = 0;
  int ne1 = 0, ns1 = 0, nerr1 = 0, nrj1 = 0;

  parking_occupancy_counter u_def (
    .clk(clk), .reset(reset), .a(a), .b(b), .clear(clear),
    .entra(e0), .sale(s0), .error(er0), .reject(rj0),
    .full(f0), .empty(em0), .count_bcd(c0)
  );

  parking_occupancy_counter #(.DIGITS(2), .CAPACITY(12), .DEBOUNCE(4)) u_sat (
    .clk(clk), .reset(reset), .a(a), .b(b), .clear(clear),
    .entra(e1), .sale(s1), .error(er1), .reject(rj1),
    .full(f1), .empty(em1), .count_bcd(c1)
  );

  always #5 clk = ~clk;

  // Pulse tallies: a pulse wider than one cycle is counted more than once.
  always @(negedge clk) begin
    if (e0)  ne0++;
    if (s0)  ns0++;
    if (er0) nerr0++;
    if (rj0) nrj0++;
    if (e1)  ne1++;
    if (s1)  ns1++;
    if (er1) nerr1++;
    if (rj1) nrj1++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold(input logic [1:0] ab, input int n);
    a = ab[1];
    b = ab[0];
    step(n);
  endtask

  task automatic entry();
    hold(2'b10, 10); hold(2'b11, 10); hold(2'b01, 10); hold(2'b00, 10);
  endtask

  task automatic exit_seq();
    hold(2'b01, 10); hold(2'b11, 10); hold(2'b10, 10); hold(2'b00, 10);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; a = 1'b0; b = 1'b0; clear = 1'b0;
    step(3);
    check("rst_count0", 32'(c0), 32'h0);
    check("rst_count1", 32'(c1), 32'h0);
    check("rst_flags0", {26'd0, e0, s0, er0, rj0, f0, em0}, 32'h1);
    check("rst_flags1", {26'd0, e1, s1, er1, rj1, f1, em1}, 32'h1);
    reset = 1'b0;
    step(2);

    // first entry with exact pulse and count timing
    hold(2'b10, 10); hold(2'b11, 10); hold(2'b01, 10);
    a = 1'b0; b = 1'b0;
    step(6);
    check("entra_early", 32'(e0), 32'h0);
    step(1);
    check("entra_pulse", 32'(e0), 32'h1);
    check("entra_pulse_sat", 32'(e1), 32'h1);
    check("count_before", 32'(c0), 32'h0);
    step(1);
    check("entra_width", 32'(e0), 32'h0);
    check("count_after", 32'(c0), 32'h0001);
    check("empty_after", 32'(em0), 32'h0);
    check("count_after_sat", 32'(c1), 32'h01);
    step(8);
    check("entra_n1", 32'(ne0), 32'd1);

    do_clear();
    check("clear_count", 32'(c0), 32'h0);
    check("clear_empty", 32'(em0), 32'h1);

    exit_seq();
    check("exit0_sale", 32'(ns0), 32'd1);
    check("exit0_reject", 32'(nrj0), 32'd1);
    check("exit0_reject_sat", 32'(nrj1), 32'd1);
    check("exit0_count", 32'(c0), 32'h0);

    entry(); entry(); entry();
    exit_seq();
    check("three_in_one_out", 32'(c0), 32'h0002);
    check("three_in_one_out_sat", 32'(c1), 32'h02);
    check("sale_n2", 32'(ns0), 32'd2);

    do_clear();
    repeat (9) entry();
    check("sat_nine", 32'(c1), 32'h09);
    check("def_nine", 32'(c0), 32'h0009);
    entry();
    check("sat_carry", 32'(c1), 32'h10);
    check("def_carry", 32'(c0), 32'h0010);
    entry(); entry();
    check("sat_twelve", 32'(c1), 32'h12);
    check("sat_full", 32'(f1), 32'h1);
    check("def_not_full", 32'(f0), 32'h0);
    entry();
    check("sat_held", 32'(c1), 32'h12);
    check("sat_reject_n", 32'(nrj1), 32'd2);
    check("def_thirteen", 32'(c0), 32'h0013);
    check("def_reject_n", 32'(nrj0), 32'd1);
    exit_seq();
    check("sat_exit", 32'(c1), 32'h11);
    check("sat_full_clr", 32'(f1), 32'h0);
    check("def_exit", 32'(c0), 32'h0012);
    check("entra_n17", 32'(ne1), 32'd17);

    hold(2'b11, 10);
    check("illegal_err", 32'(nerr0), 32'd1);
    check("illegal_err_sat", 32'(nerr1), 32'd1);
    hold(2'b00, 10);
    check("illegal_count", 32'(c1), 32'h11);
    check("illegal_no_evt", 32'(ne0 + ns0), 32'd20);

    a = 1'b1;
    step(2);
    a = 1'b0;
    step(12);
    check("glitch_quiet", 32'(ne0 + ns0 + nerr0 + nrj0), 32'd22);
    check("glitch_count", 32'(c0), 32'h0012);

    hold(2'b10, 10); hold(2'b00, 10);
    check("abandon_quiet", 32'(ne0 + ns0 + nerr0 + nrj0), 32'd22);
    entry();
    check("after_abandon_def", 32'(c0), 32'h0013);
    check("after_abandon_sat", 32'(c1), 32'h12);
    check("after_abandon_full", 32'(f1), 32'h1);

    do_clear();
    repeat (5) entry();
    check("five", 32'(c0), 32'h0005);
    hold(2'b10, 10); hold(2'b11, 10); hold(2'b01, 10);
    a = 1'b0; b = 1'b0;
    step(7);
    check("coincide_pulse", 32'(e0), 32'h1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("coincide_count", 32'(c0), 32'h0);
    check("coincide_count_sat", 32'(c1), 32'h0);
    check("coincide_noreject", 32'(rj0), 32'h0);
    step(9);
    check("coincide_rej_n", 32'(nrj0), 32'd1);
    check("coincide_entra_n", 32'(ne0), 32'd24);

    entry();
    check("pre_reset_count", 32'(c0), 32'h0001);
    hold(2'b10, 10); hold(2'b11, 10);
    #2;
    reset = 1'b1;
    a = 1'b0; b = 1'b0;
    #1;
    check("async_count", 32'(c0), 32'h0);
    check("async_flags", {26'd0, e0, s0, er0, rj0, f0, em0}, 32'h1);
    step(3);
    reset = 1'b0;
    step(5);
    entry();
    check("post_reset_count", 32'(c0), 32'h0001);
    check("post_reset_count_sat", 32'(c1), 32'h01);
    check("post_reset_entra_n", 32'(ne0), 32'd26);
    check("post_reset_err_n", 32'(nerr0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
